mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single byte-addressed 32-bit memory (en/rw/abus/dbus) between NREQ requesters, e.g. the CPU port and a loader/DMA port.
- Round-robin arbitration; each granted transaction is one word, read or write, held on the memory bus for WAIT_CYCLES clocks.
- Sits between the requesters and the memory module, inside the computer top level.

Parameters:
- NREQ, 2, number of requesters (2..4).
- WAIT_CYCLES, 1, clocks m_en is held per access (1..15).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- req_rw  in  NREQ  per-requester direction: 1=read, 0=write.
- req_addr  in  NREQ*ADDR_W  flat; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*DATA_W  flat write data, same packing.
- gnt  out  NREQ  one-hot grant; high for the whole ACCESS phase.
- done  out  NREQ  one-clock completion pulse to the owner.
- rdata  out  DATA_W  last read word; valid from done onward.
- m_en  out  1  memory enable.
- m_rw  out  1  memory direction: 1=read, 0=write.
- m_abus  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  to memory dbus_in.
- m_rdata  in  DATA_W  from memory dbus_out; Z when not enabled.

Behaviour:
- Reset values (next edge with reset=1):
  - gnt=0, done=0, rdata=0, m_en=0, m_rw=1, m_abus=0, m_wdata=0.
  - state=IDLE, rr pointer set so requester 0 wins first.
- All outputs are registered.
- States are IDLE, ACCESS, DONE.
- IDLE:
  - If any req is high at an edge, pick the first requester with req=1 searching from last_owner+1, modulo NREQ.
  - On that same edge, latch its rw/addr/wdata.
  - Set gnt[i]=1, m_en=1, m_rw, m_abus, m_wdata=(rw?0:wdata), wait counter=WAIT_CYCLES-1.
  - Go to ACCESS.
- ACCESS:
  - Outputs stay stable.
  - Counter decrements each edge.
  - On the edge where the counter is 0:
    - if read, rdata<=m_rdata;
    - m_en<=0, gnt<=0, done[i]<=1, last_owner<=i;
    - go to DONE.
- DONE:
  - done<=0.
  - m_rw<=1, m_wdata<=0; m_abus holds.
  - Go to IDLE.
- Latency: req sampled at edge k gives m_en high on k+1..k+WAIT_CYCLES and done high for one clock after edge k+WAIT_CYCLES+1. Back-to-back grants are separated by at least one DONE and one IDLE clock.
- Holding req: requesters hold req and their request fields until done. The arbiter latches at grant, so later changes are ignored for the current transaction.
- req dropped mid-ACCESS: the transaction completes; done still pulses. No abort.
- req still high after done: treated as a new request; round-robin lets the other requester win if it is waiting.
- Simultaneous requests: all requesters are served in rotation. No starvation; worst-case wait is (NREQ-1)*(WAIT_CYCLES+2) clocks.
- Writes: rdata is unchanged.
- m_rdata = Z at capture (memory address out of range): rdata captures X/Z as-is. No range check in this block.
- Reset mid-ACCESS: the transaction is dropped, no done pulse, reset values apply.

Optional Feature:
- MEMARB_STATS_EN defined:
  - adds output grant_cnt (NREQ*16, flat), a per-requester count of completed transactions;
  - each counter increments on its done pulse and saturates at 16'hFFFF;
  - cleared by reset.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package memarb_pkg:
  - state encoding IDLE=2'd0, ACCESS=2'd1, DONE=2'd2;
  - ADDR_W/DATA_W defaults;
  - RW_READ=1'b1, RW_WRITE=1'b0.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ], last_owner index.
  - Outputs: valid, winner index.
  - Reused by the arbiter's IDLE decision.

Test Plan:
- Single read: memory preloaded 0x1C=32'h00000001, WAIT_CYCLES=1; req[0]=1, rw=1, addr=0x1C -> m_en high exactly 1 clock with m_abus=0x1C; done[0] pulses 2 clocks after the request edge; rdata=32'h00000001.
- Write then read: req[1] writes 32'hDEADBEEF to 0x20, then reads 0x20 -> write cycle has m_rw=0 and m_wdata=DEADBEEF; rdata unchanged after the write; the read returns DEADBEEF.
- Contention: req[0] and req[1] both held high with reads of 0x18 and 0x1C -> grants alternate 0,1,0,1; each done is separated by 3 clocks (WAIT_CYCLES=1); no gnt overlap; gnt is always one-hot or zero.
- Wait states: WAIT_CYCLES=3, single read of 0x00 -> m_en high 3 consecutive clocks with stable m_abus; rdata=32'h001F0018.
- Abort by reset: reset asserted in the 2nd ACCESS clock (WAIT_CYCLES=3) -> next edge all outputs at reset values; no done pulse; the next request is granted to requester 0.
- Stats (MEMARB_STATS_EN): 5 reads by req0 and 3 writes by req1 -> grant_cnt = {16'd3, 16'd5}.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// memarb_pkg: shared types and constants for the memory arbiter.
//   state_t     - arbiter FSM encoding (IDLE, ACCESS, DONE)
//   ADDR_W_DEF  - default address width
//   DATA_W_DEF  - default data width
//   RW_READ / RW_WRITE - direction encoding on req_rw and m_rw
//   CNT_W       - wait counter width (WAIT_CYCLES up to 15)
//   STAT_W      - width of each per-requester completion counter
package memarb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int CNT_W  = 4;
  localparam int STAT_W = 16;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Searches req starting one past last_owner, wrapping modulo NREQ, and
// reports the first set bit.
//   req        in  NREQ   request levels
//   last_owner in  IDX_W  index of the most recent owner
//   valid      out 1      at least one request is pending
//   winner     out IDX_W  chosen requester (0 when valid=0)
module rr_pick
  import memarb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_owner,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    // k = NREQ revisits last_owner itself, so a lone repeat requester still wins
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDX_W'((int'(last_owner) + k) % NREQ);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one word-wide memory between
// NREQ requesters. Each grant performs one read or write, holding m_en for
// WAIT_CYCLES clocks, then pulses done to the owner. All outputs registered.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   req, req_rw         per-requester request level / direction (1=read)
//   req_addr, req_wdata flat per-requester address / write data
//   gnt, done           one-hot grant (ACCESS phase) / one-clock completion
//   rdata               last word read
//   m_en, m_rw, m_abus, m_wdata, m_rdata   memory bus
//   grant_cnt           per-requester completion counts (MEMARB_STATS_EN only)
//
// Optional build macro: MEMARB_STATS_EN adds grant_cnt and its counters.
//
// state  | meaning
// IDLE   | waiting for a request; picks a winner and drives the bus
// ACCESS | bus held for WAIT_CYCLES clocks; read data captured at the end
// DONE   | done pulse visible; bus direction returns to read
module mem_arbiter
  import memarb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_rw,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [DATA_W-1:0]      rdata,
  output logic                   m_en,
  output logic                   m_rw,
  output logic [ADDR_W-1:0]      m_abus,
  output logic [DATA_W-1:0]      m_wdata,
  input  logic [DATA_W-1:0]      m_rdata
`ifdef MEMARB_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0] grant_cnt
`endif
);

  localparam int IDX_W = $clog2(NREQ);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                m_en_q, m_en_d;
  logic                m_rw_q, m_rw_d;
  logic [ADDR_W-1:0]   m_abus_q, m_abus_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic                sel_rw;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req),
    .last_owner (last_q),
    .valid      (pick_valid),
    .winner     (pick_idx)
  );

  always_comb begin
    sel_rw    = RW_READ;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_rw    = req_rw[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= '0;
      // pointing at the last requester makes requester 0 the first winner
      last_q    <= IDX_W'(NREQ - 1);
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      m_en_q    <= 1'b0;
      m_rw_q    <= RW_READ;
      m_abus_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      m_en_q    <= m_en_d;
      m_rw_q    <= m_rw_d;
      m_abus_q  <= m_abus_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    m_en_d    = m_en_q;
    m_rw_d    = m_rw_q;
    m_abus_d  = m_abus_q;
    m_wdata_d = m_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d   = pick_idx;
          gnt_d     = NREQ'(1) << pick_idx;
          m_en_d    = 1'b1;
          m_rw_d    = sel_rw;
          m_abus_d  = sel_addr;
          m_wdata_d = (sel_rw == RW_READ) ? '0 : sel_wdata;
          cnt_d     = CNT_W'(WAIT_CYCLES - 1);
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (m_rw_q == RW_READ) begin
            rdata_d = m_rdata;
          end
          m_en_d  = 1'b0;
          gnt_d   = '0;
          done_d  = NREQ'(1) << owner_q;
          last_d  = owner_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        // m_abus intentionally holds the last address
        m_rw_d    = RW_READ;
        m_wdata_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign m_en    = m_en_q;
  assign m_rw    = m_rw_q;
  assign m_abus  = m_abus_q;
  assign m_wdata = m_wdata_q;

`ifdef MEMARB_STATS_EN
  logic [NREQ*STAT_W-1:0] stats_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stats_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (done_q[i] && (stats_q[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
          stats_q[i*STAT_W +: STAT_W] <= stats_q[i*STAT_W +: STAT_W] + STAT_W'(1);
        end
      end
    end
  end

  assign grant_cnt = stats_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (WAIT_CYCLES=1 and 3), each with its
// own memory, checked against a transaction-level round-robin model.
module tb_mem_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MW   = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [NREQ-1:0]    req_a     [2];
  logic [NREQ-1:0]    rw_a      [2];
  logic [NREQ*AW-1:0] addr_a    [2];
  logic [NREQ*DW-1:0] wd_a      [2];
  logic [NREQ-1:0]    gnt_a     [2];
  logic [NREQ-1:0]    done_a    [2];
  logic [DW-1:0]      rdata_a   [2];
  logic               m_en_a    [2];
  logic               m_rw_a    [2];
  logic [AW-1:0]      m_abus_a  [2];
  logic [DW-1:0]      m_wdata_a [2];
  logic [DW-1:0]      m_rdata_a [2];
`ifdef MEMARB_STATS_EN
  logic [NREQ*16-1:0] grant_cnt_a [2];
`endif

  logic [DW-1:0] phys_mem [2][MW];
  logic [DW-1:0] ref_mem  [2][MW];
  logic [DW-1:0] rdata_m  [2];
  int            last_m   [2];
  int            wait_of  [2] = '{1, 3};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc = 0;

  mem_arbiter #(.NREQ(NREQ), .WAIT_CYCLES(1), .ADDR_W(AW), .DATA_W(DW)) u_dut0 (
    .clock(clock), .reset(reset), .req(req_a[0]), .req_rw(rw_a[0]),
    .req_addr(addr_a[0]), .req_wdata(wd_a[0]), .gnt(gnt_a[0]), .done(done_a[0]),
    .rdata(rdata_a[0]), .m_en(m_en_a[0]), .m_rw(m_rw_a[0]), .m_abus(m_abus_a[0]),
    .m_wdata(m_wdata_a[0]), .m_rdata(m_rdata_a[0])
`ifdef MEMARB_STATS_EN
    , .grant_cnt(grant_cnt_a[0])
`endif
  );

  mem_arbiter #(.NREQ(NREQ), .WAIT_CYCLES(3), .ADDR_W(AW), .DATA_W(DW)) u_dut1 (
    .clock(clock), .reset(reset), .req(req_a[1]), .req_rw(rw_a[1]),
    .req_addr(addr_a[1]), .req_wdata(wd_a[1]), .gnt(gnt_a[1]), .done(done_a[1]),
    .rdata(rdata_a[1]), .m_en(m_en_a[1]), .m_rw(m_rw_a[1]), .m_abus(m_abus_a[1]),
    .m_wdata(m_wdata_a[1]), .m_rdata(m_rdata_a[1])
`ifdef MEMARB_STATS_EN
    , .grant_cnt(grant_cnt_a[1])
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input int w);
    if (w == 0) return 32'h001F0018;
    if (w == 6) return 32'h00000018;
    if (w == 7) return 32'h00000001;
    return 32'h1000_0000 + 32'(w);
  endfunction

  // memories: combinational read while enabled, write on each enabled edge
  assign m_rdata_a[0] = (m_en_a[0] && m_abus_a[0] < 32'(MW*4)) ? phys_mem[0][m_abus_a[0][7:2]] : '0;
  assign m_rdata_a[1] = (m_en_a[1] && m_abus_a[1] < 32'(MW*4)) ? phys_mem[1][m_abus_a[1][7:2]] : '0;

  initial begin
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < MW; w++) phys_mem[d][w] = init_word(w);
    forever begin
      @(posedge clock);
      for (int d = 0; d < 2; d++)
        if (m_en_a[d] && !m_rw_a[d] && m_abus_a[d] < 32'(MW*4))
          phys_mem[d][m_abus_a[d][7:2]] = m_wdata_a[d];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  function automatic int rr_model(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic post(input int d, input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    req_a[d][i] = 1'b1;
    rw_a[d][i] = rw;
    addr_a[d][i*AW +: AW] = a;
    wd_a[d][i*DW +: DW] = wd;
  endtask

  task automatic post_rand(input int d, input int i);
    post(d, i, 1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, MW-1)), 2'b00}, $urandom);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last_m[d] = NREQ - 1;
      rdata_m[d] = '0;
    end
  endtask

  // One transaction on instance d, starting with the arbiter idle.
  // got_w is the winner seen on gnt; mutate replaces the owner's request after grant.
  task automatic run_one(input int d, output int got_w, input bit mutate);
    int w, waited;
    logic er;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    logic [NREQ-1:0] eg;
    logic [67:0] bus_exp;
    got_w = -1;
    w = rr_model(req_a[d], last_m[d]);
    if (w < 0) begin
      errors++;
      $display("FAIL run_one d%0d: no request posted", d);
      return;
    end
    er = rw_a[d][w];
    ea = addr_a[d][w*AW +: AW];
    ewd = wd_a[d][w*DW +: DW];
    eg = '0;
    eg[w] = 1'b1;
    bus_exp = {eg, 1'b1, er, ea, (er ? 32'h0 : ewd)};
    waited = 0;
    do begin
      tick();
      waited++;
    end while (gnt_a[d] == '0 && waited < 20);
    got_w = (gnt_a[d] == 2'b01) ? 0 : (gnt_a[d] == 2'b10) ? 1 : -1;
    checks++;
    if (waited !== 1) begin
      errors++;
      $display("FAIL grant_latency d%0d: got %0d clocks, expected 1", d, waited);
    end
    checks++;
    if ({gnt_a[d], m_en_a[d], m_rw_a[d], m_abus_a[d], m_wdata_a[d]} !== bus_exp) begin
      errors++;
      $display("FAIL grant_bus d%0d: got %h expected %h", d,
               {gnt_a[d], m_en_a[d], m_rw_a[d], m_abus_a[d], m_wdata_a[d]}, bus_exp);
    end
    if (mutate) begin
      if ($urandom_range(0, 1) == 1) post_rand(d, w);
      else req_a[d][w] = 1'b0;
    end
    for (int c = 1; c < wait_of[d]; c++) begin
      tick();
      checks++;
      if ({gnt_a[d], m_en_a[d], m_rw_a[d], m_abus_a[d], m_wdata_a[d]} !== bus_exp || done_a[d] !== '0) begin
        errors++;
        $display("FAIL access_hold d%0d c%0d: got %h done %b expected %h done 00", d, c,
                 {gnt_a[d], m_en_a[d], m_rw_a[d], m_abus_a[d], m_wdata_a[d]}, done_a[d], bus_exp);
      end
    end
    tick();
    if (er) rdata_m[d] = ref_mem[d][ea[7:2]];
    else ref_mem[d][ea[7:2]] = ewd;
    done_cyc = cyc;
    checks++;
    if ({gnt_a[d], m_en_a[d], done_a[d], rdata_a[d]} !== {2'b00, 1'b0, eg, rdata_m[d]}) begin
      errors++;
      $display("FAIL done_pulse d%0d: got gnt %b en %b done %b rdata %h expected gnt 00 en 0 done %b rdata %h",
               d, gnt_a[d], m_en_a[d], done_a[d], rdata_a[d], eg, rdata_m[d]);
    end
    tick();
    checks++;
    if ({gnt_a[d], m_en_a[d], done_a[d], m_rw_a[d], m_abus_a[d], m_wdata_a[d]} !== {2'b00, 1'b0, 2'b00, 1'b1, ea, 32'h0}) begin
      errors++;
      $display("FAIL done_state d%0d: got gnt %b en %b done %b rw %b abus %h wdata %h expected 00 0 00 1 %h 0",
               d, gnt_a[d], m_en_a[d], done_a[d], m_rw_a[d], m_abus_a[d], m_wdata_a[d], ea);
    end
    last_m[d] = w;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({gnt_a[d], done_a[d], rdata_a[d], m_en_a[d], m_rw_a[d], m_abus_a[d], m_wdata_a[d]} !== {2'b0, 2'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0}) begin
        errors++;
        $display("FAIL reset_values d%0d: got gnt %b done %b rdata %h en %b rw %b abus %h wdata %h", d,
                 gnt_a[d], done_a[d], rdata_a[d], m_en_a[d], m_rw_a[d], m_abus_a[d], m_wdata_a[d]);
      end
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_single_read();
    int w;
    post(0, 0, 1'b1, 32'h1C, 32'h0);
    run_one(0, w, 1'b0);
    req_a[0] = '0;
    checks++;
    if (rdata_a[0] !== 32'h00000001) begin
      errors++;
      $display("FAIL single_read: got %h expected 00000001", rdata_a[0]);
    end
  endtask

  task automatic test_write_read();
    int w;
    post(0, 1, 1'b0, 32'h20, 32'hDEADBEEF);
    run_one(0, w, 1'b0);
    post(0, 1, 1'b1, 32'h20, 32'h0);
    run_one(0, w, 1'b0);
    req_a[0] = '0;
    checks++;
    if (rdata_a[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_read: got %h expected deadbeef", rdata_a[0]);
    end
  endtask

  task automatic test_contention();
    int w;
    int order [4];
    int dc [4];
    post(0, 0, 1'b1, 32'h18, 32'h0);
    post(0, 1, 1'b1, 32'h1C, 32'h0);
    for (int t = 0; t < 4; t++) begin
      run_one(0, w, 1'b0);
      order[t] = w;
      dc[t] = done_cyc;
    end
    req_a[0] = '0;
    for (int t = 0; t < 4; t++) begin
      checks++;
      if (order[t] !== t % 2) begin
        errors++;
        $display("FAIL contention_order t%0d: got %0d expected %0d", t, order[t], t % 2);
      end
    end
    for (int t = 1; t < 4; t++) begin
      checks++;
      if (dc[t] - dc[t-1] !== 3) begin
        errors++;
        $display("FAIL contention_spacing t%0d: got %0d expected 3", t, dc[t] - dc[t-1]);
      end
    end
  endtask

  task automatic test_wait_states();
    int w;
    post(1, 0, 1'b1, 32'h00, 32'h0);
    run_one(1, w, 1'b0);
    req_a[1] = '0;
    checks++;
    if (rdata_a[1] !== 32'h001F0018) begin
      errors++;
      $display("FAIL wait_states_rdata: got %h expected 001f0018", rdata_a[1]);
    end
  endtask

  task automatic test_reset_abort();
    int w;
    post(1, 0, 1'b1, 32'h04, 32'h0);
    tick();
    checks++;
    if (gnt_a[1] !== 2'b01 || m_en_a[1] !== 1'b1) begin
      errors++;
      $display("FAIL abort_grant: got gnt %b en %b expected 01 1", gnt_a[1], m_en_a[1]);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({gnt_a[1], done_a[1], rdata_a[1], m_en_a[1], m_rw_a[1], m_abus_a[1], m_wdata_a[1]} !== {2'b0, 2'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL abort_reset_values: got gnt %b done %b rdata %h en %b rw %b abus %h wdata %h",
               gnt_a[1], done_a[1], rdata_a[1], m_en_a[1], m_rw_a[1], m_abus_a[1], m_wdata_a[1]);
    end
    reset = 1'b0;
    model_reset();
    post(1, 1, 1'b1, 32'h08, 32'h0);
    run_one(1, w, 1'b0);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL abort_next_winner: got %0d expected 0", w);
    end
    run_one(1, w, 1'b0);
    req_a[1] = '0;
  endtask

  task automatic test_random(input int d, input int n);
    int w;
    for (int t = 0; t < n; t++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_a[d][i] && $urandom_range(0, 3) != 0) post_rand(d, i);
      if (req_a[d] == '0) post_rand(d, int'($urandom_range(0, NREQ-1)));
      run_one(d, w, 1'b1);
    end
    req_a[d] = '0;
  endtask

`ifdef MEMARB_STATS_EN
  task automatic test_stats();
    int w;
    test_reset();
    for (int t = 0; t < 5; t++) begin
      post(0, 0, 1'b1, 32'(4 * t), 32'h0);
      run_one(0, w, 1'b0);
    end
    req_a[0] = '0;
    for (int t = 0; t < 3; t++) begin
      post(0, 1, 1'b0, 32'h40 + 32'(4 * t), $urandom);
      run_one(0, w, 1'b0);
    end
    req_a[0] = '0;
    checks++;
    if (grant_cnt_a[0] !== {16'd3, 16'd5}) begin
      errors++;
      $display("FAIL stats_counts: got %h expected 00030005", grant_cnt_a[0]);
    end
  endtask
`endif

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_a[d] = '0;
      rw_a[d] = '0;
      addr_a[d] = '0;
      wd_a[d] = '0;
      for (int w = 0; w < MW; w++) ref_mem[d][w] = init_word(w);
    end
    model_reset();
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_wait_states();
    test_reset_abort();
    test_random(0, 40);
    test_random(1, 40);
`ifdef MEMARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
